// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state type, round constants, S-box
// and the byte/word transforms used by the round logic.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    // Indexed directly by the round counter; slots 0 and 11..15 are never used.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    // Byte 4*c+r sits at row r of column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]), mix_column(s[31:0])};
    endfunction

    function automatic logic [127:0] key_expand_step(input logic [127:0] k, input logic [7:0] c);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {c, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_round_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the
// AES-128 round controller (slave).
interface aes128_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] block;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic         busy;
    logic [3:0]   round;

    modport master (
        output in_valid, block, key, out_ready,
        input  in_ready, out_valid, result, busy, round
    );

    modport slave (
        input  in_valid, block, key, out_ready,
        output in_ready, out_valid, result, busy, round
    );
endinterface

// File: rtl/aes_round_comb.sv
// One AES-128 encryption round plus the matching key-schedule step; the final
// round skips MixColumns.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  logic         final_i,
    output logic [127:0] state_o,
    output logic [127:0] key_o
);

    logic [127:0] shifted_s;

    // Round transform with the freshly expanded key applied.
    always_comb begin
        key_o     = key_expand_step(key_i, rcon_i);
        shifted_s = shift_rows(sub_bytes(state_i));
        if (final_i) begin
            state_o = shifted_s ^ key_o;
        end else begin
            state_o = mix_columns(shifted_s) ^ key_o;
        end
    end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller, one round per clock.
// Optional AES_CTRL_ABORT_EN adds an abort input that cancels a running block.
module aes128_round_ctrl
    import aes_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
`ifdef AES_CTRL_ABORT_EN
    input  logic abort,
`endif
    aes128_round_ctrl_if.slave bus
);

    fsm_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] result_q, result_d;
    logic [3:0]   round_q, round_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic [127:0] next_state_s;
    logic [127:0] next_key_s;

    aes_round_comb u_round (
        .state_i (state_q),
        .key_i   (key_q),
        .rcon_i  (RCON[round_q]),
        .final_i (fsm_q == ST_FINAL),
        .state_o (next_state_s),
        .key_o   (next_key_s)
    );

    // Next-state logic for the sequencer and all datapath registers.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        result_d    = result_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    fsm_d   = ST_ROUND;
                    state_d = bus.block ^ bus.key;
                    key_d   = bus.key;
                    round_d = 4'd1;
                    busy_d  = 1'b1;
                end else begin
                    round_d = 4'd0;
                end
            end
            ST_ROUND: begin
                state_d = next_state_s;
                key_d   = next_key_s;
                round_d = round_q + 4'd1;
                if (round_q == 4'd9) begin
                    fsm_d = ST_FINAL;
                end else begin
                    fsm_d = ST_ROUND;
                end
            end
            ST_FINAL: begin
                fsm_d       = ST_DONE;
                state_d     = next_state_s;
                key_d       = next_key_s;
                result_d    = next_state_s;
                round_d     = 4'd10;
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
            end
            ST_DONE: begin
                // Taking the result and offering a new block in one cycle chains straight on.
                if (bus.out_ready && bus.in_valid) begin
                    fsm_d       = ST_ROUND;
                    state_d     = bus.block ^ bus.key;
                    key_d       = bus.key;
                    round_d     = 4'd1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end else if (bus.out_ready) begin
                    fsm_d       = ST_IDLE;
                    round_d     = 4'd0;
                    out_valid_d = 1'b0;
                end else begin
                    fsm_d = ST_DONE;
                end
            end
            default: begin
                fsm_d       = ST_IDLE;
                round_d     = 4'd0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
`ifdef AES_CTRL_ABORT_EN
        if (abort && ((fsm_q == ST_ROUND) || (fsm_q == ST_FINAL))) begin
            fsm_d       = ST_IDLE;
            state_d     = 128'h0;
            key_d       = 128'h0;
            result_d    = result_q;
            round_d     = 4'd0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
        end
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= 128'h0;
            key_q       <= 128'h0;
            result_q    <= 128'h0;
            round_q     <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            result_q    <= result_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
    assign bus.round     = round_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed and randomized bench for aes128_round_ctrl against an array-based
// AES-128 model whose S-box is derived from GF(2^8) inversion.
module tb_aes128_round_ctrl;

    logic clk;
    logic reset_n;
`ifdef AES_CTRL_ABORT_EN
    logic abort;
`endif
    int compared;
    int mismatched;
    logic [7:0] sb [0:255];

    aes128_round_ctrl_if bus ();

    aes128_round_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef AES_CTRL_ABORT_EN
        .abort   (abort),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sb[x] = b;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] blk, input logic [127:0] k);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c+0] = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        o = 128'h0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, 128'(bus.out_valid), 128'd0);
        check({tag, " busy"}, 128'(bus.busy), 128'd0);
        check({tag, " in_ready"}, 128'(bus.in_ready), 128'd1);
        check({tag, " round"}, 128'(bus.round), 128'd0);
    endtask

    task automatic accept(input logic [127:0] blk, input logic [127:0] k);
        bus.in_valid = 1'b1;
        bus.block    = blk;
        bus.key      = k;
        tick();
        bus.in_valid = 1'b0;
        bus.block    = rand128();
        bus.key      = rand128();
    endtask

    // Called right after the accept edge; walks the busy period to DONE.
    task automatic wait_done(input string tag, input logic [127:0] exp);
        int   edges;
        int   busy_cnt;
        logic seq_ok;
        edges    = 0;
        busy_cnt = 0;
        seq_ok   = 1'b1;
        while (!bus.out_valid && edges < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.round !== 4'(edges + 1)) seq_ok = 1'b0;
            if (bus.in_ready !== 1'b0) seq_ok = 1'b0;
            tick();
            edges++;
        end
        check({tag, " latency"}, 128'(edges), 128'd10);
        check({tag, " busy cycles"}, 128'(busy_cnt), 128'd10);
        check({tag, " round/in_ready seq"}, 128'(seq_ok), 128'd1);
        check({tag, " result"}, bus.result, exp);
        check({tag, " done round"}, 128'(bus.round), 128'd10);
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_idle({tag, " after take"});
    endtask

    logic [127:0] b_blk, b_key, b_ct, c_blk, c_key, c_ct;
    logic [127:0] r_blk, r_key, held;
    logic         stable_ok;
    int           n;

    initial begin
        compared   = 0;
        mismatched = 0;
        b_blk = 128'h3243f6a8885a308d313198a2e0370734;
        b_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        b_ct  = 128'h3925841d02dc09fbdc118597196a0b32;
        c_blk = 128'h00112233445566778899aabbccddeeff;
        c_key = 128'h000102030405060708090a0b0c0d0e0f;
        c_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        build_sbox();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.block     = 128'h0;
        bus.key       = 128'h0;
`ifdef AES_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        check_idle("reset");
        check("reset result", bus.result, 128'h0);

        // FIPS-197 appendix B and C.1 vectors.
        accept(b_blk, b_key);
        wait_done("appB", b_ct);
        take("appB");
        accept(c_blk, c_key);
        wait_done("appC1", c_ct);

        // Backpressure, then a back-to-back accept in the same cycle as the take.
        held      = bus.result;
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.result !== held || bus.in_ready !== 1'b0) stable_ok = 1'b0;
        end
        check("backpressure stable", 128'(stable_ok), 128'd1);
        r_blk = rand128();
        r_key = rand128();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.block     = r_blk;
        bus.key       = r_key;
        #1;
        check("done in_ready follows out_ready", 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.block     = rand128();
        wait_done("back2back", aes_ref(r_blk, r_key));
        take("back2back");

        // Activity on the request side while busy is ignored.
        accept(b_blk, b_key);
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.in_ready !== 1'b0) stable_ok = 1'b0;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.block    = rand128();
            tick();
        end
        bus.in_valid = 1'b0;
        check("ignore busy in_ready", 128'(stable_ok), 128'd1);
        check("ignore busy out_valid", 128'(bus.out_valid), 128'd1);
        check("ignore busy result", bus.result, b_ct);
        take("ignore busy");

        // Reset in the middle of round 5.
        accept(c_blk, c_key);
        n = 0;
        while (bus.round !== 4'd5 && n < 20) begin
            tick();
            n++;
        end
        check("reach round5", 128'(bus.round), 128'd5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_idle("midreset");
        check("midreset result", bus.result, 128'h0);
        stable_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) stable_ok = 1'b0;
        end
        check("midreset no out_valid", 128'(stable_ok), 128'd1);
        accept(b_blk, b_key);
        wait_done("appB after reset", b_ct);
        take("appB after reset");

`ifdef AES_CTRL_ABORT_EN
        accept(b_blk, b_key);
        n = 0;
        while (bus.round !== 4'd3 && n < 20) begin
            tick();
            n++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        stable_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) stable_ok = 1'b0;
        end
        check("abort no out_valid", 128'(stable_ok), 128'd1);
        accept(c_blk, c_key);
        wait_done("appC1 after abort", c_ct);
        take("appC1 after abort");
`endif

        // Random blocks against the reference model with random consumer stalls.
        for (int t = 0; t < 6; t++) begin
            r_blk = rand128();
            r_key = rand128();
            accept(r_blk, r_key);
            wait_done("random", aes_ref(r_blk, r_key));
            n = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) tick();
            check("random held", bus.result, aes_ref(r_blk, r_key));
            take("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
